// File: rtl/load_store_unit_if.sv
// Request/response bus between the datapath and the load/store unit, plus the word-wide memory port.
// master = datapath and memory side, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              busy;
    logic              fault;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport master (
        output req, wr, size, sign_ext, addr, wdata, mem_rd,
        input  rdata, done, busy, fault, mem_a, mem_we, mem_wd
    );

    modport slave (
        input  req, wr, size, sign_ext, addr, wdata, mem_rd,
        output rdata, done, busy, fault, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer: turns byte/half/word requests into aligned big-endian word reads and RMW stores.
// Latency accept->done: load 2, word store 2, sub-word store 3 cycles; MISALIGN_TRAP_EN adds fault traps (1 cycle).
// Backpressure: req is sampled only in IDLE; requests arriving while busy are dropped, never queued.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 100
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              fault_q;
    logic              we_q;
    logic              fault_c;

    // Pick the addressed lane out of a big-endian word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'd0;
        h = 16'd0;
        r = w;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    b = w[31:24];
                    2'd1:    b = w[23:16];
                    2'd2:    b = w[15:8];
                    default: b = w[7:0];
                endcase
                r = {{24{sx & b[7]}}, b};
            end
            2'b01: begin
                h = off[1] ? w[15:0] : w[31:16];
                r = {{16{sx & h[15]}}, h};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the right-justified store data.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    r = {d[7:0], w[23:0]};
                    2'd1:    r = {w[31:24], d[7:0], w[15:0]};
                    2'd2:    r = {w[31:16], d[7:0], w[7:0]};
                    default: r = {w[31:8], d[7:0]};
                endcase
            end
            2'b01:   r = off[1] ? {w[31:16], d[15:0]} : {d[15:0], w[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic [ADDR_W:0] last_byte;
    logic            misaligned;

    // Extra top bit keeps the +3 from wrapping near the top of the address space.
    assign last_byte  = {1'b0, bus.addr[ADDR_W-1:2], 2'b00} + (ADDR_W+1)'(3);
    assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                        (bus.size[1] && (bus.addr[1:0] != 2'b00));
    assign fault_c    = misaligned || (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`else
    assign fault_c    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            wdata_q    <= 32'd0;
            word_q     <= 32'd0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        addr_q     <= bus.addr;
                        wr_q       <= bus.wr;
                        size_q     <= bus.size;
                        sign_ext_q <= bus.sign_ext;
                        wdata_q    <= bus.wdata;
                        fault_q    <= fault_c;
                        if (fault_c) begin
                            rdata_q <= 32'd0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else if (!bus.wr || !bus.size[1]) begin
                            state <= RD;
                        end else begin
                            we_q  <= 1'b1;
                            state <= WR;
                        end
                    end
                end
                RD: begin
                    word_q <= bus.mem_rd;
                    if (wr_q) begin
                        we_q  <= 1'b1;
                        state <= WR;
                    end else begin
                        rdata_q <= extract(bus.mem_rd, addr_q[1:0], size_q, sign_ext_q);
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                WR: begin
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_we = we_q;
    // word_q only matters for sub-word stores; merge() passes wdata_q through for words.
    assign bus.mem_wd = merge(word_q, addr_q[1:0], size_q, wdata_q);
    assign bus.rdata  = rdata_q;
    assign bus.done   = done_q;
    assign bus.fault  = fault_q;
    assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array big-endian memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    load_store_unit_if #(.ADDR_W(32)) bus();

    load_store_unit #(.ADDR_W(32), .MEM_BYTES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:255];
    logic       poke_en = 1'b0;
    logic [7:0] poke_a  = 8'd0;
    logic [7:0] poke_d  = 8'd0;
    logic [7:0] ma;

    assign ma         = bus.mem_a[7:0];
    assign bus.mem_rd = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        if (bus.mem_we) begin
            mem[ma]        <= bus.mem_wd[31:24];
            mem[ma + 8'd1] <= bus.mem_wd[23:16];
            mem[ma + 8'd2] <= bus.mem_wd[15:8];
            mem[ma + 8'd3] <= bus.mem_wd[7:0];
        end
    end

    function automatic logic [31:0] peek(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // One access from IDLE; inputs are scrambled right after accept. Returns in IDLE.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int edges, output logic [31:0] rd, output logic flt,
                          output int we_cnt, output logic busy1);
        bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.wr = ~w; bus.size = ~sz; bus.sign_ext = ~sx;
        bus.addr = ~a; bus.wdata = ~d;
        edges  = 1;
        we_cnt = 0;
        busy1  = bus.busy;
        while (!bus.done && edges < 10) begin
            if (bus.mem_we) we_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        if (!bus.done) begin
            checks++; failures++;
            $display("FAIL access_timeout done=%b required=1 within 10 cycles", bus.done);
        end
        rd  = bus.rdata;
        flt = bus.fault;
        if (bus.mem_we) we_cnt++;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL done_single_pulse done=%b busy=%b required done=0 busy=0", bus.done, bus.busy);
        end
    endtask

    int          e, wc;
    logic [31:0] rd;
    logic        flt, b1;

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        for (int i = 0; i < 104; i++) poke(8'(i), 8'h00);
        poke(8'd0, 8'h11); poke(8'd1, 8'h22); poke(8'd2, 8'h33); poke(8'd3, 8'h44);
        checks += 7;
        if (bus.rdata  !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h required=0", bus.rdata); end
        if (bus.done   !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b required=0", bus.done); end
        if (bus.busy   !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b required=0", bus.busy); end
        if (bus.fault  !== 1'b0)  begin failures++; $display("FAIL reset_fault got=%b required=0", bus.fault); end
        if (bus.mem_we !== 1'b0)  begin failures++; $display("FAIL reset_mem_we got=%b required=0", bus.mem_we); end
        if (bus.mem_a  !== 32'd0) begin failures++; $display("FAIL reset_mem_a got=%h required=0", bus.mem_a); end
        if (bus.mem_wd !== 32'd0) begin failures++; $display("FAIL reset_mem_wd got=%h required=0", bus.mem_wd); end
        reset = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, e, rd, flt, wc, b1);
        checks += 5;
        if (rd  !== 32'h11223344) begin failures++; $display("FAIL word_load0 got=%h required=11223344", rd); end
        if (e   !== 2)            begin failures++; $display("FAIL word_load_latency got=%0d required=2", e); end
        if (flt !== 1'b0)         begin failures++; $display("FAIL word_load_fault got=%b required=0", flt); end
        if (wc  !== 0)            begin failures++; $display("FAIL word_load_we got=%0d required=0", wc); end
        if (b1  !== 1'b1)         begin failures++; $display("FAIL word_load_busy got=%b required=1", b1); end
    endtask

    task automatic test_loads();
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin sz = 2'b00; sx = 1'b0; a = 32'd2; exp = 32'h00000033; end
                1: begin sz = 2'b01; sx = 1'b1; a = 32'd2; exp = 32'h00003344; end
                2: begin sz = 2'b00; sx = 1'b1; a = 32'd1; exp = 32'hFFFFFF80; end
                3: begin sz = 2'b00; sx = 1'b0; a = 32'd1; exp = 32'h00000080; end
                4: begin sz = 2'b00; sx = 1'b1; a = 32'd3; exp = 32'h00000044; end
                5: begin sz = 2'b01; sx = 1'b1; a = 32'd0; exp = 32'hFFFF9180; end
                default: begin sz = 2'b11; sx = 1'b1; a = 32'd0; exp = 32'h91803344; end
            endcase
            if (i == 2) poke(8'd1, 8'h80);
            if (i == 5) poke(8'd0, 8'h91);
            access(1'b0, sz, sx, a, 32'd0, e, rd, flt, wc, b1);
            checks += 3;
            if (rd !== exp)  begin failures++; $display("FAIL load_vec%0d got=%h required=%h", i, rd, exp); end
            if (e  !== 2)    begin failures++; $display("FAIL load_vec%0d_latency got=%0d required=2", i, e); end
            if (flt !== 1'b0) begin failures++; $display("FAIL load_vec%0d_fault got=%b required=0", i, flt); end
        end
        poke(8'd0, 8'h11);
    endtask

    task automatic test_stores();
        access(1'b1, 2'b00, 1'b0, 32'd1, 32'h000000AB, e, rd, flt, wc, b1);
        checks += 3;
        if (peek(0) !== 32'h11AB3344) begin failures++; $display("FAIL store_byte1 got=%h required=11AB3344", peek(0)); end
        if (e  !== 3) begin failures++; $display("FAIL store_byte_latency got=%0d required=3", e); end
        if (wc !== 1) begin failures++; $display("FAIL store_byte_we got=%0d required=1", wc); end
        access(1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF, e, rd, flt, wc, b1);
        checks += 4;
        if (peek(4) !== 32'hDEADBEEF) begin failures++; $display("FAIL store_word4 got=%h required=DEADBEEF", peek(4)); end
        if (peek(0) !== 32'h11AB3344) begin failures++; $display("FAIL store_word_neighbour got=%h required=11AB3344", peek(0)); end
        if (e  !== 2) begin failures++; $display("FAIL store_word_latency got=%0d required=2", e); end
        if (wc !== 1) begin failures++; $display("FAIL store_word_we got=%0d required=1", wc); end
    endtask

    task automatic test_half_store();
        poke(8'd1, 8'h22);
        access(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000CAFE, e, rd, flt, wc, b1);
        checks += 3;
        if (peek(0) !== 32'h1122CAFE) begin failures++; $display("FAIL store_half2 got=%h required=1122CAFE", peek(0)); end
        if (e  !== 3) begin failures++; $display("FAIL store_half_latency got=%0d required=3", e); end
        if (wc !== 1) begin failures++; $display("FAIL store_half_we got=%0d required=1", wc); end
        access(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, e, rd, flt, wc, b1);
        checks++;
        if (rd !== 32'h1122CAFE) begin failures++; $display("FAIL readback_half got=%h required=1122CAFE", rd); end
    endtask

    task automatic test_back_to_back();
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0; bus.addr = 32'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept1 busy=%b required=1", bus.busy); end
        bus.addr = 32'd3;
        @(posedge clk); #1;
        checks += 2;
        if (bus.done  !== 1'b1)         begin failures++; $display("FAIL b2b_done1 got=%b required=1", bus.done); end
        if (bus.rdata !== 32'h00000011) begin failures++; $display("FAIL b2b_rdata1 got=%h required=00000011", bus.rdata); end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL b2b_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept2 busy=%b required=1", bus.busy); end
        bus.req = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (bus.done  !== 1'b1)         begin failures++; $display("FAIL b2b_done2 got=%b required=1", bus.done); end
        if (bus.rdata !== 32'h000000FE) begin failures++; $display("FAIL b2b_rdata2 got=%h required=000000FE", bus.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wr();
        logic saw_done;
        saw_done = 1'b0;
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'd3; bus.wdata = 32'h00000055;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rst_wr_in_wr mem_we=%b required=1", bus.mem_we); end
        reset = 1'b1;
        #1;
        checks += 2;
        if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_wr_we_drop got=%b required=0", bus.mem_we); end
        if (bus.busy   !== 1'b0) begin failures++; $display("FAIL rst_wr_busy got=%b required=0", bus.busy); end
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        checks += 4;
        if (saw_done !== 1'b0)        begin failures++; $display("FAIL rst_wr_done got=%b required=0", saw_done); end
        if (peek(0) !== 32'h1122CAFE) begin failures++; $display("FAIL rst_wr_mem got=%h required=1122CAFE", peek(0)); end
        if (bus.busy !== 1'b0)        begin failures++; $display("FAIL rst_wr_busy_after got=%b required=0", bus.busy); end
        if (bus.rdata !== 32'd0)      begin failures++; $display("FAIL rst_wr_rdata got=%h required=0", bus.rdata); end
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        access(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, e, rd, flt, wc, b1);
        access(1'b0, 2'b10, 1'b0, 32'd2, 32'd0, e, rd, flt, wc, b1);
        checks += 4;
        if (flt !== 1'b1)  begin failures++; $display("FAIL trap_word2_fault got=%b required=1", flt); end
        if (rd  !== 32'd0) begin failures++; $display("FAIL trap_word2_rdata got=%h required=0", rd); end
        if (wc  !== 0)     begin failures++; $display("FAIL trap_word2_we got=%0d required=0", wc); end
        if (e   !== 1)     begin failures++; $display("FAIL trap_word2_latency got=%0d required=1", e); end
        access(1'b1, 2'b01, 1'b0, 32'd99, 32'h00001234, e, rd, flt, wc, b1);
        checks += 4;
        if (flt !== 1'b1)  begin failures++; $display("FAIL trap_half99_fault got=%b required=1", flt); end
        if (rd  !== 32'd0) begin failures++; $display("FAIL trap_half99_rdata got=%h required=0", rd); end
        if (wc  !== 0)     begin failures++; $display("FAIL trap_half99_we got=%0d required=0", wc); end
        if (peek(96) !== 32'd0) begin failures++; $display("FAIL trap_half99_mem got=%h required=0", peek(96)); end
        access(1'b0, 2'b00, 1'b0, 32'd100, 32'd0, e, rd, flt, wc, b1);
        checks++;
        if (flt !== 1'b1) begin failures++; $display("FAIL trap_byte100_fault got=%b required=1", flt); end
        access(1'b0, 2'b00, 1'b0, 32'd99, 32'd0, e, rd, flt, wc, b1);
        checks += 2;
        if (flt !== 1'b0) begin failures++; $display("FAIL trap_byte99_fault got=%b required=0", flt); end
        if (e   !== 2)    begin failures++; $display("FAIL trap_byte99_latency got=%0d required=2", e); end
`else
        access(1'b0, 2'b10, 1'b0, 32'd2, 32'd0, e, rd, flt, wc, b1);
        checks += 3;
        if (rd  !== 32'h1122CAFE) begin failures++; $display("FAIL word2_alias got=%h required=1122CAFE", rd); end
        if (flt !== 1'b0)         begin failures++; $display("FAIL word2_fault got=%b required=0", flt); end
        if (e   !== 2)            begin failures++; $display("FAIL word2_latency got=%0d required=2", e); end
        access(1'b0, 2'b01, 1'b0, 32'd1, 32'd0, e, rd, flt, wc, b1);
        checks++;
        if (rd !== 32'h00001122) begin failures++; $display("FAIL half1_alias got=%h required=00001122", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_half_store();
        test_back_to_back();
        test_reset_in_wr();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not reach the summary");
        $fatal(1);
    end

endmodule
